// File: rtl/mult_pkg.sv
// Shared constants, row type and skew helper for the pipelined 8x8 unsigned multiplier.
package mult_pkg;

    localparam int unsigned N          = 32'd8;
    localparam int unsigned PW         = 32'd16;
    localparam int unsigned REDUCE_LAT = 32'd7;

    typedef logic [PW-1:0] pp_row_t;

    // Extra register stages row i needs so it lands when the reduction stage samples it.
    function automatic int unsigned skew(input int unsigned i);
        if (i < 32'd3) begin
            return 32'd0;
        end else begin
            return i - 32'd2;
        end
    endfunction

endpackage

// File: rtl/partial_product_skew_8x8_skew_delay_line.sv
// W-bit register chain of DEPTH stages with synchronous active-low clear.
// DEPTH=0 degenerates to a plain wire.
module skew_delay_line #(
    parameter int unsigned W     = 32'd16,
    parameter int unsigned DEPTH = 32'd1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] data,
    output logic [W-1:0] delayed
);

    generate
        if (DEPTH == 32'd0) begin : g_pass
            assign delayed = data;
        end else begin : g_regs
            logic [W-1:0] stage_r [DEPTH];

            // Shift chain; reset empties every slot so in-flight rows are dropped.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int k = 0; k < int'(DEPTH); k++) begin
                        stage_r[k] <= '0;
                    end
                end else begin
                    stage_r[0] <= data;
                    for (int k = 1; k < int'(DEPTH); k++) begin
                        stage_r[k] <= stage_r[k-1];
                    end
                end
            end

            assign delayed = stage_r[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/partial_product_skew_8x8.sv
// Partial-product generator and time skew feeding the ripple reduction pipeline,
// plus the valid tag aligned with the reduction stage's final product.
module partial_product_skew_8x8
    import mult_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  a,
    input  logic [N-1:0]  b,
    input  logic          in_valid,
    output pp_row_t       P0,
    output pp_row_t       P1,
    output pp_row_t       P2,
    output pp_row_t       P3,
    output pp_row_t       P4,
    output pp_row_t       P5,
    output pp_row_t       P6,
    output pp_row_t       P7,
    output logic          pp_valid,
    output logic          prod_valid
);

    logic [N-1:0] a_q_r;
    logic [N-1:0] b_q_r;
    logic         v_q_r;
    pp_row_t      rows_s   [N];
    pp_row_t      skewed_s [N];

    // Operand capture; a bubble loads zeros so it contributes all-zero rows downstream.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_q_r <= '0;
            b_q_r <= '0;
            v_q_r <= 1'b0;
        end else if (in_valid) begin
            a_q_r <= a;
            b_q_r <= b;
            v_q_r <= 1'b1;
        end else begin
            a_q_r <= '0;
            b_q_r <= '0;
            v_q_r <= 1'b0;
        end
    end

    // Zero-extended shifted rows; the widest (a=0xFF, i=7) still fits in PW bits.
    always_comb begin
        for (int i = 0; i < int'(N); i++) begin
            rows_s[i] = b_q_r[i] ? (PW'(a_q_r) << i) : '0;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < int'(N); gi++) begin : g_row
            if (skew(gi) == 32'd0) begin : g_direct
                assign skewed_s[gi] = rows_s[gi];
            end else begin : g_delay
                skew_delay_line #(
                    .W     (PW),
                    .DEPTH (skew(gi))
                ) u_skew (
                    .clk     (clk),
                    .rst_n   (rst_n),
                    .data    (rows_s[gi]),
                    .delayed (skewed_s[gi])
                );
            end
        end
    endgenerate

    skew_delay_line #(
        .W     (32'd1),
        .DEPTH (REDUCE_LAT)
    ) u_prod_valid (
        .clk     (clk),
        .rst_n   (rst_n),
        .data    (v_q_r),
        .delayed (prod_valid)
    );

    assign P0       = skewed_s[0];
    assign P1       = skewed_s[1];
    assign P2       = skewed_s[2];
    assign P3       = skewed_s[3];
    assign P4       = skewed_s[4];
    assign P5       = skewed_s[5];
    assign P6       = skewed_s[6];
    assign P7       = skewed_s[7];
    assign pp_valid = v_q_r;

endmodule

// File: tb/tb_partial_product_skew_8x8.sv
// Self-checking bench: per-edge operation history model, a software reduction of the
// observed rows into products, and directed literal checks plus randomized traffic.
module tb_partial_product_skew_8x8;
    import mult_pkg::*;

    localparam int MAXC = 1024;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic [7:0] a;
    logic [7:0] b;
    pp_row_t    P0, P1, P2, P3, P4, P5, P6, P7;
    logic       pp_valid;
    logic       prod_valid;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = -1;
    int last_reset  = -1;

    bit          hv  [MAXC];
    logic [7:0]  ha  [MAXC];
    logic [7:0]  hb  [MAXC];
    logic [16:0] acc [MAXC];

    partial_product_skew_8x8 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (a),
        .b          (b),
        .in_valid   (in_valid),
        .P0         (P0),
        .P1         (P1),
        .P2         (P2),
        .P3         (P3),
        .P4         (P4),
        .P5         (P5),
        .P6         (P6),
        .P7         (P7),
        .pp_valid   (pp_valid),
        .prod_valid (prod_valid)
    );

    always #5 clk = ~clk;

    function automatic logic op_alive(input int s);
        if (s < 0 || last_reset >= s) return 1'b0;
        return hv[s];
    endfunction

    function automatic logic [15:0] exp_row(input int s, input int i);
        logic [15:0] x;
        if (!op_alive(s)) return 16'h0000;
        x = {8'h00, ha[s]};
        return hb[s][i] ? (x << i) : 16'h0000;
    endfunction

    task automatic chk(input string name, input logic [16:0] act, input logic [16:0] exp_v);
        vectors++;
        if (act !== exp_v) begin
            miscompares++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp_v);
        end
    endtask

    // Record the operation sampled at each edge, then check all outputs against the model.
    always @(posedge clk) begin
        pp_row_t rows [8];
        int s;
        cyc++;
        if (cyc >= MAXC) begin
            $display("FAIL cycle_budget: got %0d cycles, expected fewer than %0d", cyc, MAXC);
            $fatal(1);
        end
        hv[cyc]  = (in_valid === 1'b1) && (rst_n === 1'b1);
        ha[cyc]  = a;
        hb[cyc]  = b;
        acc[cyc] = 17'd0;
        if (rst_n !== 1'b1) last_reset = cyc;
        #1;
        rows = '{P0, P1, P2, P3, P4, P5, P6, P7};
        for (int i = 0; i < 8; i++) begin
            s = (i < 3) ? cyc : cyc - (i - 2);
            chk($sformatf("P%0d", i), {1'b0, rows[i]}, {1'b0, exp_row(s, i)});
            if (s >= 0) acc[s] = acc[s] + {1'b0, rows[i]};
        end
        chk("pp_valid", {16'd0, pp_valid}, {16'd0, op_alive(cyc)});
        chk("prod_valid", {16'd0, prod_valid}, {16'd0, op_alive(cyc - 7)});
        if (op_alive(cyc - 7)) begin
            chk("final_prod", acc[cyc-7], {9'd0, ha[cyc-7]} * {9'd0, hb[cyc-7]});
        end
    end

    task automatic drive(input logic r, input logic v, input logic [7:0] x, input logic [7:0] y);
        @(negedge clk);
        rst_n    = r;
        in_valid = v;
        a        = x;
        b        = y;
        @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) drive(1'b1, 1'b0, 8'($urandom), 8'($urandom));
    endtask

    initial begin
        int e;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = 8'h00;
        b        = 8'h00;

        // Reset with random operands on the bus
        drive(1'b0, 1'($urandom), 8'($urandom), 8'($urandom));
        chk("rst_P0", {1'b0, P0}, 17'h0);
        chk("rst_prod_valid", {16'd0, prod_valid}, 17'h0);
        drive(1'b0, 1'($urandom), 8'($urandom), 8'($urandom));
        chk("rst_P7", {1'b0, P7}, 17'h0);
        chk("rst_pp_valid", {16'd0, pp_valid}, 17'h0);

        // 0xFF * 0xFF
        drive(1'b1, 1'b1, 8'hFF, 8'hFF);
        e = cyc;
        chk("ff_P0", {1'b0, P0}, 17'h000FF);
        chk("ff_P1", {1'b0, P1}, 17'h001FE);
        chk("ff_P2", {1'b0, P2}, 17'h003FC);
        idle(1);
        chk("ff_P3", {1'b0, P3}, 17'h007F8);
        idle(4);
        chk("ff_P7", {1'b0, P7}, 17'h07F80);
        idle(2);
        chk("ff_prod_valid", {16'd0, prod_valid}, 17'h1);
        chk("ff_final", acc[e], 17'h0FE01);
        idle(1);
        chk("ff_prod_valid_end", {16'd0, prod_valid}, 17'h0);

        // Back-to-back operations
        drive(1'b1, 1'b1, 8'd3, 8'd5);
        e = cyc;
        drive(1'b1, 1'b1, 8'd200, 8'd100);
        drive(1'b1, 1'b1, 8'hAA, 8'h55);
        idle(4);
        chk("b2b_pv_before", {16'd0, prod_valid}, 17'h0);
        idle(1);
        chk("b2b_pv0", {16'd0, prod_valid}, 17'h1);
        chk("b2b_final0", acc[e], 17'h0000F);
        idle(1);
        chk("b2b_pv1", {16'd0, prod_valid}, 17'h1);
        chk("b2b_final1", acc[e+1], 17'h04E20);
        idle(1);
        chk("b2b_pv2", {16'd0, prod_valid}, 17'h1);
        chk("b2b_final2", acc[e+2], 17'h03872);
        idle(1);
        chk("b2b_pv_after", {16'd0, prod_valid}, 17'h0);

        // Only the top row set
        drive(1'b1, 1'b1, 8'h01, 8'h80);
        e = cyc;
        chk("top_P0", {1'b0, P0}, 17'h0);
        idle(5);
        chk("top_P7", {1'b0, P7}, 17'h00080);
        idle(2);
        chk("top_final", acc[e], 17'h00080);

        // Bubble with 0xFF operands between two ops
        drive(1'b1, 1'b1, 8'd3, 8'd5);
        drive(1'b1, 1'b0, 8'hFF, 8'hFF);
        e = cyc;
        chk("bub_P0", {1'b0, P0}, 17'h0);
        chk("bub_P2", {1'b0, P2}, 17'h0);
        chk("bub_pp_valid", {16'd0, pp_valid}, 17'h0);
        drive(1'b1, 1'b1, 8'd2, 8'd2);
        idle(6);
        chk("bub_prod_valid", {16'd0, prod_valid}, 17'h0);
        idle(1);
        chk("bub_next_final", acc[e+1], 17'h00004);

        // Reset mid-flight discards the op; the next op completes normally
        drive(1'b1, 1'b1, 8'd7, 8'd9);
        e = cyc;
        idle(2);
        drive(1'b0, 1'($urandom), 8'($urandom), 8'($urandom));
        chk("kill_P0", {1'b0, P0}, 17'h0);
        chk("kill_P3", {1'b0, P3}, 17'h0);
        chk("kill_pp_valid", {16'd0, pp_valid}, 17'h0);
        drive(1'b1, 1'b1, 8'h0C, 8'h0B);
        idle(3);
        chk("kill_no_prod_valid", {16'd0, prod_valid}, 17'h0);
        idle(4);
        chk("kill_next_prod_valid", {16'd0, prod_valid}, 17'h1);
        chk("kill_next_final", acc[e+4], 17'h00084);

        // Randomized traffic with occasional resets
        for (int n = 0; n < 300; n++) begin
            drive(($urandom_range(0, 39) != 0) ? 1'b1 : 1'b0, 1'($urandom),
                  8'($urandom), 8'($urandom));
        end
        idle(10);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
